// File: rtl/axis_fifo_master_pkt.sv
// AXI4-Stream master fed from a 1-cycle-latency FIFO through a small output buffer; TLAST comes from pkt_len.
// Define M_AXIS_STATS_EN to add the beat_count/pkt_count statistics outputs.
module axis_fifo_master_pkt #(
  parameter int C_M_AXIS_TDATA_WIDTH = 32,
  parameter int C_BUF_DEPTH          = 2,
  parameter int C_PKT_LEN_WIDTH      = 16
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESETN,
  output logic                            M_AXIS_TVALID,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                            M_AXIS_TLAST,
  input  logic                            M_AXIS_TREADY,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_dout,
  output logic                            fifo_rd_en,
  input  logic                            fifo_empty,
  input  logic                            enable,
  input  logic [C_PKT_LEN_WIDTH-1:0]      pkt_len,
  output logic                            busy
`ifdef M_AXIS_STATS_EN
  ,
  output logic [31:0]                     beat_count,
  output logic [31:0]                     pkt_count
`endif
);

  localparam int DW  = C_M_AXIS_TDATA_WIDTH;
  localparam int PLW = C_PKT_LEN_WIDTH;
  localparam int AW  = (C_BUF_DEPTH > 1) ? $clog2(C_BUF_DEPTH) : 1;

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN  = 3'b010;
  localparam logic [2:0] S_STOP = 3'b100;

  logic [2:0]             state;
  logic [2:0]             state_nxt;
  logic [DW-1:0]          buf_data [C_BUF_DEPTH];
  logic [C_BUF_DEPTH-1:0] buf_last;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [AW:0]            occ;
  logic                   inflight;
  logic                   inflight_last;
  logic [PLW-1:0]         tag_cnt;
  logic [PLW-1:0]         tag_len;
  logic [PLW-1:0]         eff_len;
  logic                   tag_is_last;
  logic                   can_read;
  logic                   push;
  logic                   pop;
  logic [AW+1:0]          credit;

  assign M_AXIS_TVALID = (occ != '0);
  assign M_AXIS_TDATA  = buf_data[rd_ptr];
  assign M_AXIS_TLAST  = M_AXIS_TVALID & buf_last[rd_ptr];

  assign pop  = M_AXIS_TVALID & M_AXIS_TREADY;
  assign push = inflight;

  // Packet position is tracked at read-issue time; the flag then rides along with the beat into the buffer.
  assign eff_len     = (tag_cnt == '0) ? ((pkt_len == '0) ? PLW'(1) : pkt_len) : tag_len;
  assign tag_is_last = (tag_cnt == eff_len - PLW'(1));

  assign credit     = {1'b0, occ} + {{(AW+1){1'b0}}, inflight} - {{(AW+1){1'b0}}, pop};
  assign fifo_rd_en = can_read & ~fifo_empty & (credit < (AW+2)'(C_BUF_DEPTH));

  assign busy = (state != S_IDLE) | (occ != '0) | inflight;

  // A RUN cycle with enable low on a packet boundary must not open a new packet.
  always_comb begin
    can_read = 1'b0;
    case (state)
      S_RUN:   can_read = enable | (tag_cnt != '0);
      S_STOP:  can_read = 1'b1;
      default: can_read = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (enable) state_nxt = S_RUN;
      S_RUN: begin
        if (!enable) begin
          if (tag_cnt == '0 || (fifo_rd_en && tag_is_last)) state_nxt = S_IDLE;
          else                                                state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (enable)                         state_nxt = S_RUN;
        else if (fifo_rd_en && tag_is_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      state         <= S_IDLE;
      occ           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      tag_cnt       <= '0;
      tag_len       <= '0;
      buf_last      <= '0;
      for (int i = 0; i < C_BUF_DEPTH; i++) buf_data[i] <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        inflight_last <= tag_is_last;
        tag_cnt       <= tag_is_last ? '0 : tag_cnt + PLW'(1);
        if (tag_cnt == '0) tag_len <= eff_len;
      end
      if (push) begin
        buf_data[wr_ptr] <= fifo_dout;
        buf_last[wr_ptr] <= inflight_last;
        wr_ptr           <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

`ifdef M_AXIS_STATS_EN
  always_ff @(posedge M_AXIS_ACLK) begin
    if (!M_AXIS_ARESETN) begin
      beat_count <= '0;
      pkt_count  <= '0;
    end else if (pop) begin
      beat_count <= beat_count + 32'd1;
      if (M_AXIS_TLAST) pkt_count <= pkt_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_fifo_master_pkt.sv
// Scoreboard bench for axis_fifo_master_pkt: a FIFO model feeds the DUT, expected beats are queued at load time.
// Build with M_AXIS_STATS_EN defined to also check the statistics counters.
module tb_axis_fifo_master_pkt;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int PLW   = 16;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           tvalid;
  logic [DW-1:0]  tdata;
  logic           tlast;
  logic           tready = 1'b0;
  logic [DW-1:0]  fifo_dout = '0;
  logic           fifo_rd_en;
  logic           fifo_empty;
  logic           enable = 1'b0;
  logic [PLW-1:0] pkt_len = '0;
  logic           busy;
`ifdef M_AXIS_STATS_EN
  logic [31:0]    beat_count;
  logic [31:0]    pkt_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  axis_fifo_master_pkt #(
    .C_M_AXIS_TDATA_WIDTH(DW),
    .C_BUF_DEPTH(DEPTH),
    .C_PKT_LEN_WIDTH(PLW)
  ) dut (
    .M_AXIS_ACLK(clk),
    .M_AXIS_ARESETN(rstn),
    .M_AXIS_TVALID(tvalid),
    .M_AXIS_TDATA(tdata),
    .M_AXIS_TLAST(tlast),
    .M_AXIS_TREADY(tready),
    .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en),
    .fifo_empty(fifo_empty),
    .enable(enable),
    .pkt_len(pkt_len),
    .busy(busy)
`ifdef M_AXIS_STATS_EN
    ,
    .beat_count(beat_count),
    .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  // Standard FIFO model: data appears on fifo_dout the cycle after a pop request.
  logic [DW-1:0] fmem [256];
  int            wr_idx = 0;
  int            rd_idx = 0;
  logic          fifo_flush = 1'b0;

  assign fifo_empty = (rd_idx == wr_idx);

  always @(posedge clk) begin
    if (fifo_flush) rd_idx <= wr_idx;
    else if (fifo_rd_en && !fifo_empty) begin
      fifo_dout <= fmem[rd_idx[7:0]];
      rd_idx    <= rd_idx + 1;
    end
  end

  // TREADY pattern: 0 always high, 1 toggling, 2 random, other always low.
  int ready_mode = 0;
  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = ~tready;
      2:       tready = 1'($urandom_range(0, 1));
      default: tready = 1'b0;
    endcase
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  beat_t sb_q[$];
  int    cyc = 0;
  int    first_rd_cyc = -1;
  int    first_vld_cyc = -1;
  int    last_xfer_cyc = -1;
  int    accepted = 0;
  int    rd_total = 0;
  int    outstanding = 0;
  logic  prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic  prev_last = 1'b0;

  // Monitor: pops the scoreboard on every transfer and checks handshake rules between edges.
  always @(negedge clk) begin
    beat_t exp_b;
    logic  pop_now;
    cyc++;
    if (!rstn) begin
      sb_q.delete();
      first_rd_cyc  = -1;
      first_vld_cyc = -1;
      last_xfer_cyc = -1;
      accepted      = 0;
      rd_total      = 0;
      outstanding   = 0;
      prev_stall    = 1'b0;
    end else begin
      pop_now = tvalid & tready;
      if (prev_stall) begin
        checkOutput("hold_tvalid", 64'(tvalid), 64'd1);
        checkOutput("hold_tdata", 64'(tdata), 64'(prev_data));
        checkOutput("hold_tlast", 64'(tlast), 64'(prev_last));
      end
      if (fifo_rd_en) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_total++;
        checkOutput("rd_credit_ok", 64'((outstanding - int'(pop_now)) < DEPTH), 64'd1);
      end
      if (tvalid && first_vld_cyc < 0) first_vld_cyc = cyc;
      if (pop_now) begin
        if (sb_q.size() == 0) begin
          checkOutput("unexpected_beat", 64'(tdata), 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          exp_b = sb_q.pop_front();
          checkOutput("beat_tdata", 64'(tdata), 64'(exp_b.data));
          checkOutput("beat_tlast", 64'(tlast), 64'(exp_b.last));
        end
        accepted++;
        last_xfer_cyc = cyc;
      end
      outstanding = outstanding + int'(fifo_rd_en) - int'(pop_now);
      prev_stall  = tvalid & ~tready;
      prev_data   = tdata;
      prev_last   = tlast;
    end
  end

  // Load one word into the FIFO and, if it is expected to come out, queue its reference beat.
  task automatic applyStimulus(input logic [DW-1:0] data, input int idx, input int len, input bit expect_out);
    fmem[wr_idx[7:0]] = data;
    wr_idx++;
    if (expect_out) sb_q.push_back('{data: data, last: ((idx % len) == len - 1)});
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    rstn       = 1'b0;
    enable     = 1'b0;
    fifo_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rstn       = 1'b1;
    fifo_flush = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int k = 0;
    while (sb_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("drain_remaining", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic waitAccepted(input int n, input int budget);
    int k = 0;
    while (accepted < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("accept_wait", 64'(accepted >= n), 64'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int len;
    int n;
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("rst_tlast", 64'(tlast), 64'd0);
    checkOutput("rst_tdata", 64'(tdata), 64'd0);
    checkOutput("rst_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);

    // Back-to-back streaming, two packets of 4.
    doReset();
    ready_mode = 0;
    pkt_len    = 16'd4;
    for (int i = 0; i < 8; i++) applyStimulus(32'h10 + 32'(i), i, 4, 1'b1);
    enable = 1'b1;
    waitDrain(100);
    checkOutput("first_valid_latency", 64'(first_vld_cyc - first_rd_cyc), 64'd2);
    checkOutput("consecutive_span", 64'(last_xfer_cyc - first_vld_cyc), 64'd7);
    checkOutput("t1_accepted", 64'(accepted), 64'd8);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t1_busy_after", 64'(busy), 64'd0);
`ifdef M_AXIS_STATS_EN
    checkOutput("t1_beat_count", 64'(beat_count), 64'd8);
    checkOutput("t1_pkt_count", 64'(pkt_count), 64'd2);
`endif

    // Same data with TREADY toggling every cycle.
    doReset();
    ready_mode = 1;
    pkt_len    = 16'd4;
    for (int i = 0; i < 8; i++) applyStimulus(32'h10 + 32'(i), i, 4, 1'b1);
    enable = 1'b1;
    waitDrain(200);
    checkOutput("t2_accepted", 64'(accepted), 64'd8);

    // FIFO runs dry mid-packet: the packet must stay open.
    doReset();
    ready_mode = 0;
    pkt_len    = 16'd3;
    applyStimulus(32'hA0, 0, 3, 1'b1);
    applyStimulus(32'hA1, 1, 3, 1'b1);
    enable = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("gap_accepted", 64'(accepted), 64'd2);
    checkOutput("gap_tvalid", 64'(tvalid), 64'd0);
    applyStimulus(32'hA2, 2, 3, 1'b1);
    waitDrain(50);

    // pkt_len of zero behaves as single-beat packets.
    doReset();
    ready_mode = 0;
    pkt_len    = 16'd0;
    for (int i = 0; i < 3; i++) applyStimulus(32'hB0 + 32'(i), i, 1, 1'b1);
    enable = 1'b1;
    waitDrain(50);
    checkOutput("len0_accepted", 64'(accepted), 64'd3);

    // enable dropped after beat 2: the packet completes and nothing more is read.
    doReset();
    ready_mode = 0;
    pkt_len    = 16'd4;
    for (int i = 0; i < 8; i++) applyStimulus(32'hC0 + 32'(i), i, 4, i < 4);
    enable = 1'b1;
    waitAccepted(2, 50);
    enable = 1'b0;
    waitDrain(50);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("stop_accepted", 64'(accepted), 64'd4);
    checkOutput("stop_reads", 64'(rd_total), 64'd4);
    checkOutput("stop_busy", 64'(busy), 64'd0);

    // Reset pulse while the buffer is full.
    doReset();
    ready_mode = 0;
    pkt_len    = 16'd4;
    for (int i = 0; i < 8; i++) applyStimulus(32'hD0 + 32'(i), i, 4, 1'b1);
    enable = 1'b1;
    waitAccepted(3, 50);
    ready_mode = 3;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("pre_reset_tvalid", 64'(tvalid), 64'd1);
    rstn       = 1'b0;
    enable     = 1'b0;
    fifo_flush = 1'b1;
    @(posedge clk);
    #1;
    rstn       = 1'b1;
    fifo_flush = 1'b0;
    checkOutput("mid_rst_tvalid", 64'(tvalid), 64'd0);
    checkOutput("mid_rst_rd_en", 64'(fifo_rd_en), 64'd0);
    checkOutput("mid_rst_tlast", 64'(tlast), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
`ifdef M_AXIS_STATS_EN
    checkOutput("mid_rst_beat_count", 64'(beat_count), 64'd0);
    checkOutput("mid_rst_pkt_count", 64'(pkt_count), 64'd0);
`endif

    // Randomized rounds: random lengths, data, FIFO gaps and backpressure.
    for (int r = 0; r < 4; r++) begin
      doReset();
      ready_mode = 2;
      pkt_len    = 16'($urandom_range(0, 5));
      len        = (pkt_len == 0) ? 1 : int'(pkt_len);
      n          = int'($urandom_range(8, 24));
      enable     = 1'b1;
      for (int i = 0; i < n; i++) begin
        applyStimulus($urandom, i, len, 1'b1);
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
        @(posedge clk);
        #1;
      end
      waitDrain(600);
      checkOutput("rand_accepted", 64'(accepted), 64'(n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
